// File: rtl/pipe_pkg.sv
// Control-word definitions shared by the EX/MEM/WB control pipeline.
package pipe_pkg;

  localparam int PIPE_REG_W = 5;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2,
    ALU_RSVD  = 2'd3
  } alu_op_e;

  typedef struct packed {
    logic                  valid;
    logic                  reg_dst;
    logic                  branch;
    logic                  mem_read;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic                  alu_src;
    logic                  reg_write;
    alu_op_e               alu_op;
    logic [PIPE_REG_W-1:0] dest;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage of control word; clear or reset loads a bubble.
module ctrl_stage_reg
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  ctrl_word_t d,
  output ctrl_word_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= CTRL_BUBBLE;
    end else if (clear) begin
      q <= CTRL_BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// EX/MEM/WB control pipeline with load-use stall and taken-branch squash.
module ctrl_pipe
  import pipe_pkg::*;
#(
  parameter int REG_W = PIPE_REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_reg_dst,
  input  logic             id_branch,
  input  logic             id_mem_read,
  input  logic             id_mem_to_reg,
  input  logic             id_mem_write,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic [1:0]       id_alu_op,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             mem_zero,
  output logic             stall,
  output logic             pc_src,
  output logic             ex_valid,
  output logic             ex_alu_src,
  output logic             ex_reg_dst,
  output logic [1:0]       ex_alu_op,
  output logic [REG_W-1:0] ex_dest,
  output logic             mem_valid,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_branch,
  output logic [REG_W-1:0] mem_dest,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic [REG_W-1:0] wb_dest
);

  ctrl_word_t id_w;
  ctrl_word_t ex_q;
  ctrl_word_t mem_q;
  ctrl_word_t wb_q;
  logic       hazard;
  logic       ex_clear;
  logic       mem_clear;

  // An invalid ID slot enters EX as a bubble, so it can never raise a hazard.
  always_comb begin
    id_w = CTRL_BUBBLE;
    if (id_valid) begin
      id_w.valid      = 1'b1;
      id_w.reg_dst    = id_reg_dst;
      id_w.branch     = id_branch;
      id_w.mem_read   = id_mem_read;
      id_w.mem_to_reg = id_mem_to_reg;
      id_w.mem_write  = id_mem_write;
      id_w.alu_src    = id_alu_src;
      id_w.reg_write  = id_reg_write;
      id_w.alu_op     = alu_op_e'(id_alu_op);
      id_w.dest       = PIPE_REG_W'(id_reg_dst ? id_rd : id_rt);
    end
  end

  always_comb begin
    hazard = id_valid & ex_q.valid & ex_q.mem_read & (ex_dest != '0)
           & ((ex_dest == id_rs) | (ex_dest == id_rt));
    pc_src = mem_q.valid & mem_q.branch & mem_zero;
    // A taken branch kills the dependent instruction anyway, so no stall.
    stall     = hazard & ~pc_src;
    ex_clear  = hazard | pc_src;
    mem_clear = pc_src;
  end

  ctrl_stage_reg u_ex_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (ex_clear),
    .d     (id_w),
    .q     (ex_q)
  );

  ctrl_stage_reg u_mem_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (mem_clear),
    .d     (ex_q),
    .q     (mem_q)
  );

  ctrl_stage_reg u_wb_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .d     (mem_q),
    .q     (wb_q)
  );

  always_comb begin
    ex_valid      = ex_q.valid;
    ex_alu_src    = ex_q.alu_src;
    ex_reg_dst    = ex_q.reg_dst;
    ex_alu_op     = ex_q.alu_op;
    ex_dest       = REG_W'(ex_q.dest);
    mem_valid     = mem_q.valid;
    mem_read      = mem_q.mem_read;
    mem_write     = mem_q.mem_write;
    mem_branch    = mem_q.branch;
    mem_dest      = REG_W'(mem_q.dest);
    wb_valid      = wb_q.valid;
    wb_reg_write  = wb_q.reg_write;
    wb_mem_to_reg = wb_q.mem_to_reg;
    wb_dest       = REG_W'(wb_q.dest);
  end

  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_q.reg_dst, wb_q.branch, wb_q.mem_read,
                              wb_q.mem_write, wb_q.alu_src, wb_q.alu_op};

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed checks for ctrl_pipe: stage latency, load-use stall, branch squash, reset.
module tb_ctrl_pipe;

  logic       clk, rst_n;
  logic       id_valid, id_reg_dst, id_branch, id_mem_read, id_mem_to_reg;
  logic       id_mem_write, id_alu_src, id_reg_write;
  logic [1:0] id_alu_op;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       mem_zero;
  logic       stall, pc_src;
  logic       ex_valid, ex_alu_src, ex_reg_dst;
  logic [1:0] ex_alu_op;
  logic [4:0] ex_dest;
  logic       mem_valid, mem_read, mem_write, mem_branch;
  logic [4:0] mem_dest;
  logic       wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [4:0] wb_dest;

  int checks = 0;
  int errors = 0;

  ctrl_pipe #(.REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_reg_dst(id_reg_dst),
    .id_branch(id_branch), .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_alu_op(id_alu_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .mem_zero(mem_zero), .stall(stall), .pc_src(pc_src), .ex_valid(ex_valid),
    .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_alu_op(ex_alu_op),
    .ex_dest(ex_dest), .mem_valid(mem_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_branch(mem_branch), .mem_dest(mem_dest),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_dest(wb_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [28:0] all_outs();
    return {stall, pc_src, ex_valid, ex_alu_src, ex_reg_dst, ex_alu_op, ex_dest,
            mem_valid, mem_read, mem_write, mem_branch, mem_dest,
            wb_valid, wb_reg_write, wb_mem_to_reg, wb_dest};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic rdst, input logic br, input logic mr,
                        input logic m2r, input logic mw, input logic asrc, input logic rw,
                        input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
    id_valid = v; id_reg_dst = rdst; id_branch = br; id_mem_read = mr;
    id_mem_to_reg = m2r; id_mem_write = mw; id_alu_src = asrc; id_reg_write = rw;
    id_alu_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (all_outs() !== '0) begin errors++; $display("FAIL reset_async got %h exp 0", all_outs()); end
    set_id(1, 1, 0, 0, 0, 0, 0, 1, 2'd2, 5'd1, 5'd2, 5'd3);
    step();
    checks++; if (all_outs() !== '0) begin errors++; $display("FAIL reset_held got %h exp 0", all_outs()); end
    #2 rst_n = 1'b1;
    step();
    checks++; if (ex_valid !== 1'b1 || ex_dest !== 5'd3) begin errors++; $display("FAIL reset_release_ex got v=%b d=%0d exp v=1 d=3", ex_valid, ex_dest); end
    idle();
    step(); step(); step();
  endtask

  task automatic test_rtype();
    set_id(1, 1, 0, 0, 0, 0, 0, 1, 2'd2, 5'd1, 5'd2, 5'd3);
    step();
    checks++; if ({ex_valid, ex_reg_dst, ex_alu_src, ex_alu_op, ex_dest} !== {1'b1, 1'b1, 1'b0, 2'd2, 5'd3}) begin errors++; $display("FAIL rtype_ex got v=%b rd=%b as=%b op=%0d d=%0d exp 1 1 0 2 3", ex_valid, ex_reg_dst, ex_alu_src, ex_alu_op, ex_dest); end
    idle();
    step();
    checks++; if ({mem_valid, mem_dest, ex_valid} !== {1'b1, 5'd3, 1'b0}) begin errors++; $display("FAIL rtype_mem got v=%b d=%0d exv=%b exp 1 3 0", mem_valid, mem_dest, ex_valid); end
    step();
    checks++; if ({wb_valid, wb_reg_write, wb_mem_to_reg, wb_dest} !== {1'b1, 1'b1, 1'b0, 5'd3}) begin errors++; $display("FAIL rtype_wb got v=%b rw=%b m2r=%b d=%0d exp 1 1 0 3", wb_valid, wb_reg_write, wb_mem_to_reg, wb_dest); end
    step();
  endtask

  task automatic test_load_use();
    set_id(1, 0, 0, 1, 1, 0, 1, 1, 2'd0, 5'd1, 5'd5, 5'd0);
    step();
    checks++; if (ex_dest !== 5'd5 || ex_alu_src !== 1'b1) begin errors++; $display("FAIL lu_ex_dest got d=%0d as=%b exp 5 1", ex_dest, ex_alu_src); end
    set_id(1, 1, 0, 0, 0, 0, 0, 1, 2'd2, 5'd5, 5'd6, 5'd7);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", stall); end
    step();
    checks++; if ({ex_valid, mem_valid, mem_read, mem_dest, stall} !== {1'b0, 1'b1, 1'b1, 5'd5, 1'b0}) begin errors++; $display("FAIL lu_bubble got exv=%b mv=%b mr=%b md=%0d st=%b exp 0 1 1 5 0", ex_valid, mem_valid, mem_read, mem_dest, stall); end
    step();
    checks++; if ({ex_valid, ex_dest, mem_valid, stall} !== {1'b1, 5'd7, 1'b0, 1'b0}) begin errors++; $display("FAIL lu_dep_in_ex got exv=%b d=%0d mv=%b st=%b exp 1 7 0 0", ex_valid, ex_dest, mem_valid, stall); end
    idle();
    step(); step();
  endtask

  task automatic test_load_zero();
    set_id(1, 0, 0, 1, 1, 0, 1, 1, 2'd0, 5'd1, 5'd0, 5'd0);
    step();
    set_id(1, 1, 0, 0, 0, 0, 0, 1, 2'd2, 5'd0, 5'd0, 5'd4);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lz_stall got %b exp 0", stall); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_dest !== 5'd4) begin errors++; $display("FAIL lz_no_bubble got v=%b d=%0d exp 1 4", ex_valid, ex_dest); end
    idle();
    step(); step(); step();
  endtask

  task automatic test_idle_no_hazard();
    set_id(1, 0, 0, 1, 1, 0, 1, 1, 2'd0, 5'd1, 5'd5, 5'd0);
    step();
    set_id(0, 1, 0, 0, 0, 0, 0, 1, 2'd2, 5'd5, 5'd5, 5'd7);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall got %b exp 0", stall); end
    step();
    checks++; if (ex_valid !== 1'b0 || ex_dest !== 5'd0) begin errors++; $display("FAIL idle_bubble got v=%b d=%0d exp 0 0", ex_valid, ex_dest); end
    idle();
    step(); step(); step();
  endtask

  task automatic test_branch();
    mem_zero = 1'b0;
    set_id(1, 0, 1, 0, 0, 0, 0, 0, 2'd1, 5'd1, 5'd2, 5'd0);
    step();
    set_id(1, 1, 0, 0, 0, 0, 0, 1, 2'd2, 5'd3, 5'd4, 5'd8);
    step();
    checks++; if ({mem_valid, mem_branch, ex_valid, ex_dest} !== {1'b1, 1'b1, 1'b1, 5'd8}) begin errors++; $display("FAIL br_setup got mv=%b mb=%b exv=%b exd=%0d exp 1 1 1 8", mem_valid, mem_branch, ex_valid, ex_dest); end
    set_id(1, 1, 0, 0, 0, 0, 0, 1, 2'd2, 5'd3, 5'd4, 5'd9);
    #1;
    checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL br_not_taken got %b exp 0", pc_src); end
    mem_zero = 1'b1;
    #1;
    checks++; if (pc_src !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL br_taken got pc=%b st=%b exp 1 0", pc_src, stall); end
    step();
    mem_zero = 1'b0;
    checks++; if ({ex_valid, mem_valid, wb_valid, wb_dest, wb_reg_write} !== {1'b0, 1'b0, 1'b1, 5'd2, 1'b0}) begin errors++; $display("FAIL br_squash got exv=%b mv=%b wv=%b wd=%0d wrw=%b exp 0 0 1 2 0", ex_valid, mem_valid, wb_valid, wb_dest, wb_reg_write); end
    idle();
    step(); step(); step();
  endtask

  task automatic test_branch_hazard();
    mem_zero = 1'b0;
    set_id(1, 0, 1, 0, 0, 0, 0, 0, 2'd1, 5'd1, 5'd2, 5'd0);
    step();
    set_id(1, 0, 0, 1, 1, 0, 1, 1, 2'd0, 5'd1, 5'd5, 5'd0);
    step();
    set_id(1, 1, 0, 0, 0, 0, 0, 1, 2'd2, 5'd6, 5'd5, 5'd7);
    #1;
    checks++; if (stall !== 1'b1 || pc_src !== 1'b0) begin errors++; $display("FAIL bh_nt got st=%b pc=%b exp 1 0", stall, pc_src); end
    mem_zero = 1'b1;
    #1;
    checks++; if (stall !== 1'b0 || pc_src !== 1'b1) begin errors++; $display("FAIL bh_taken got st=%b pc=%b exp 0 1", stall, pc_src); end
    step();
    mem_zero = 1'b0;
    checks++; if ({ex_valid, mem_valid, wb_valid, wb_dest} !== {1'b0, 1'b0, 1'b1, 5'd2}) begin errors++; $display("FAIL bh_squash got exv=%b mv=%b wv=%b wd=%0d exp 0 0 1 2", ex_valid, mem_valid, wb_valid, wb_dest); end
    idle();
    step(); step(); step();
  endtask

  task automatic test_back_to_back();
    set_id(1, 1, 0, 0, 0, 0, 0, 1, 2'd2, 5'd1, 5'd2, 5'd10);
    step();
    set_id(1, 1, 0, 0, 0, 0, 0, 1, 2'd2, 5'd10, 5'd2, 5'd11);
    step();
    set_id(1, 1, 0, 0, 0, 1, 1, 0, 2'd0, 5'd11, 5'd10, 5'd12);
    step();
    checks++; if ({ex_dest, mem_dest, wb_dest, wb_valid, stall} !== {5'd12, 5'd11, 5'd10, 1'b1, 1'b0}) begin errors++; $display("FAIL b2b_dests got ex=%0d mem=%0d wb=%0d wv=%b st=%b exp 12 11 10 1 0", ex_dest, mem_dest, wb_dest, wb_valid, stall); end
    idle();
    step();
    checks++; if ({mem_write, mem_dest, ex_valid} !== {1'b1, 5'd12, 1'b0}) begin errors++; $display("FAIL b2b_store got mw=%b md=%0d exv=%b exp 1 12 0", mem_write, mem_dest, ex_valid); end
    step(); step();
  endtask

  task automatic test_reset_mid();
    set_id(1, 1, 0, 0, 0, 0, 0, 1, 2'd2, 5'd1, 5'd2, 5'd13);
    step();
    set_id(1, 1, 0, 0, 0, 0, 0, 1, 2'd2, 5'd1, 5'd2, 5'd14);
    step();
    mem_zero = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (all_outs() !== '0) begin errors++; $display("FAIL rst_mid got %h exp 0", all_outs()); end
    set_id(1, 1, 0, 0, 0, 0, 0, 1, 2'd2, 5'd1, 5'd2, 5'd15);
    mem_zero = 1'b0;
    #2 rst_n = 1'b1;
    step();
    checks++; if ({ex_valid, ex_dest, mem_valid, wb_valid} !== {1'b1, 5'd15, 1'b0, 1'b0}) begin errors++; $display("FAIL rst_mid_release got exv=%b d=%0d mv=%b wv=%b exp 1 15 0 0", ex_valid, ex_dest, mem_valid, wb_valid); end
    idle();
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    mem_zero = 1'b0;
    idle();
    test_reset();
    test_rtype();
    test_load_use();
    test_load_zero();
    test_idle_no_hazard();
    test_branch();
    test_branch_hazard();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the decode-stage control word produced by the control unit through the EX, MEM and WB stages of the 5-stage MIPS pipeline. It is the consumer end of the control-signal interface. Each cycle it presents the per-stage control signals and destination register to the datapath. It detects load-use hazards and raises a stall, and it squashes younger instructions when a branch resolves taken in MEM.

## Interface
Parameters:
- REG_W, default 5: register-index width.

Ports:
- clk  in  1: pipeline clock; all state updates on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- id_valid  in  1: the ID stage holds a real instruction.
- id_reg_dst, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in  1 each: control-unit outputs for the ID instruction.
- id_alu_op  in  2: ALU operation class.
- id_rs, id_rt, id_rd  in  REG_W: register fields of the ID instruction.
- mem_zero  in  1: ALU zero flag of the instruction now in MEM.
- stall  out  1: freeze the PC and the IF/ID register (combinational).
- pc_src  out  1: branch taken; select the branch target (combinational).
- ex_valid, ex_alu_src, ex_reg_dst  out  1: EX-stage control.
- ex_alu_op  out  2: EX-stage ALU operation class.
- ex_dest  out  REG_W: EX-stage destination register.
- mem_valid, mem_read, mem_write, mem_branch  out  1: MEM-stage control.
- mem_dest  out  REG_W: MEM-stage destination register.
- wb_valid, wb_reg_write, wb_mem_to_reg  out  1: WB-stage control.
- wb_dest  out  REG_W: WB-stage destination register.

## Operation
- Three stage registers hold the control word: EX, MEM and WB. Each word carries valid, every control bit, alu_op and dest.
- A bubble is a word with every field zero.
- dest is fixed on entry to EX as id_reg_dst ? id_rd : id_rt. Downstream stages copy it unchanged.
- Load-use hazard condition: id_valid & ex_valid & ex_mem_read & ex_dest != 0 & (ex_dest == id_rs | ex_dest == id_rt).
  - While this holds, stall = 1 and a bubble enters EX.
  - MEM and WB advance normally.
- Branch condition: pc_src = mem_valid & mem_branch & mem_zero.
  - When pc_src = 1, bubbles enter EX and MEM, killing the ID and EX instructions.
  - WB takes the old MEM word, so the branch itself still retires.
- Simultaneous events:
  - pc_src and the hazard true together: pc_src wins; stall is forced to 0 and the same bubbles are inserted.
  - id_valid = 0: a bubble enters EX; no hazard is possible.
- Writes to register 0: wb_reg_write is passed through unchanged. The register file ignores writes to index 0.
- Reset: all three stage registers clear to bubble immediately, without waiting for clk. Every output reads 0 during and after reset, including stall and pc_src.
- Reset mid-operation discards all in-flight words. The first word after reset deassertion is captured on the first rising edge with rst_n = 1.

## Timing
- Latency from ID to the stage outputs: EX 1 cycle, MEM 2 cycles, WB 3 cycles.
- stall and pc_src are combinational from current state and inputs in the same cycle. They settle before the edge that acts on them.
- A load-use stall lasts exactly one cycle per hazard. In the next cycle the load sits in MEM, the bubble in EX, and the hazard condition is false.
- A taken branch costs 3 cycles: the IF/ID squash is the datapath's job, and this block squashes ID and EX.
- No stage register ever holds a word: every stage advances every cycle and stall only replaces the EX input.

## Structure
- Shared package pipe_pkg holds:
  - the typedef ctrl_word_t: packed valid, reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op[1:0], dest[REG_W-1:0];
  - the constant CTRL_BUBBLE = all zeros.
- Sub-module ctrl_stage_reg: one ctrl_word_t register with a clear input that loads CTRL_BUBBLE, reset to CTRL_BUBBLE. It is instantiated three times.
- The top level holds the hazard compare, the branch decode and the dest mux.

## Test plan
- R-type stream: R-type with rd = 3 (reg_dst = 1, reg_write = 1) → ex_dest = 3 at cycle +1, mem_dest = 3 at +2, wb_dest = 3 with wb_reg_write = 1 at +3.
- Load-use: lw with rt = 5 followed by an instruction with rs = 5 → stall = 1 for exactly one cycle, ex_valid = 0 next cycle, the dependent instruction in EX one cycle later.
- Load to $0: lw with rt = 0 followed by a use of rs = 0 → stall stays 0.
- Taken branch: beq reaches MEM with mem_zero = 1 → pc_src = 1 that cycle, ex_valid = 0 and mem_valid = 0 next cycle, wb_valid = 1 carrying the beq.
- Branch plus hazard in the same cycle → stall = 0, pc_src = 1, both bubbles inserted.
- Assert rst_n = 0 mid-stream between clock edges → every output reads 0 immediately. After release, the next ID word appears in EX after one edge.
